// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - start/busy/done scheduled serial pattern scan over a captured word
module seq_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5,
  parameter int POS_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [POS_W-1:0]  first_pos
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shift_reg, shift_reg_n;
  logic [PAT_W-1:0]    pat_r, pat_r_n;
  logic                ovl_r, ovl_r_n;
  logic [PAT_W-1:0]    window, window_n;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [POS_W-1:0]    idx, idx_n;
  logic                busy_n, done_n, found_n;
  logic [CNT_W-1:0]    match_cnt_n;
  logic [POS_W-1:0]    first_pos_n;

  logic                bit_b;
  logic [PAT_W-1:0]    win_next;
  logic [FILL_W-1:0]   fill_inc;
  logic                hit;

  // Matcher view of the bit leaving the MSB this cycle.
  assign bit_b    = shift_reg[DATA_W-1];
  assign win_next = {window[PAT_W-2:0], bit_b};
  assign fill_inc = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
  assign hit      = (fill_inc == FILL_W'(PAT_W)) && (win_next == pat_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      pat_r     <= '0;
      ovl_r     <= 1'b0;
      window    <= '0;
      fill      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_reg_n;
      pat_r     <= pat_r_n;
      ovl_r     <= ovl_r_n;
      window    <= window_n;
      fill      <= fill_n;
      idx       <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      found     <= found_n;
      match_cnt <= match_cnt_n;
      first_pos <= first_pos_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_reg_n = shift_reg;
    pat_r_n     = pat_r;
    ovl_r_n     = ovl_r;
    window_n    = window;
    fill_n      = fill;
    idx_n       = idx;
    busy_n      = busy;
    done_n      = 1'b0;
    found_n     = found;
    match_cnt_n = match_cnt;
    first_pos_n = first_pos;

    case (state)
      IDLE: begin
        if (start) begin
          shift_reg_n = data_in;
          pat_r_n     = pattern;
          ovl_r_n     = overlap;
          window_n    = '0;
          fill_n      = '0;
          idx_n       = '0;
          found_n     = 1'b0;
          match_cnt_n = '0;
          first_pos_n = '0;
          busy_n      = 1'b1;
          state_n     = SHIFT;
        end
      end

      SHIFT: begin
        shift_reg_n = {shift_reg[DATA_W-2:0], 1'b0};
        window_n    = win_next;
        // Non-overlapping mode forces a fresh PAT_W bits after every hit.
        fill_n      = (hit && !ovl_r) ? '0 : fill_inc;
        if (hit) begin
          if (match_cnt != {CNT_W{1'b1}})
            match_cnt_n = match_cnt + 1'b1;
          if (!found) begin
            found_n     = 1'b1;
            first_pos_n = idx;
          end
        end
        idx_n = idx + 1'b1;
        if (idx == POS_W'(DATA_W - 1)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  pattern;
  logic        overlap;

  logic        busy, done, found;
  logic [4:0]  match_cnt;
  logic [3:0]  first_pos;

  logic        b_busy, b_done, b_found;
  logic [2:0]  b_match_cnt;
  logic [3:0]  b_first_pos;

  int checks = 0;
  int errors = 0;
  int lat, bcyc, pulses;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(5)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pattern(pattern),
    .overlap(overlap), .busy(busy), .done(done), .found(found),
    .match_cnt(match_cnt), .first_pos(first_pos)
  );

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pattern(pattern),
    .overlap(overlap), .busy(b_busy), .done(b_done), .found(b_found),
    .match_cnt(b_match_cnt), .first_pos(b_first_pos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; the start edge is the next posedge.
  // lat = edges after the start edge until done is seen (0 = timeout).
  task automatic run_scan(input logic [15:0] d, input logic [3:0] p, input logic o,
                          output int lat_o, output int busy_o);
    data_in = d; pattern = p; overlap = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_o = busy ? 1 : 0;
    lat_o = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat_o = i;
        break;
      end
      if (busy) busy_o++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; pattern = '0; overlap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_pos", first_pos, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single match at the MSB end; done seen by a sampler at the 17th edge.
    run_scan(16'hD000, 4'b1101, 1'b0, lat, bcyc);
    chk("d000_latency", lat, 16);
    chk("d000_busy_cycles", bcyc, 16);
    chk("d000_busy_at_done", busy, 0);
    chk("d000_found", found, 1);
    chk("d000_cnt", match_cnt, 1);
    chk("d000_pos", first_pos, 3);
    @(posedge clk); #1;
    chk("d000_done_one_cycle", done, 0);
    chk("d000_hold_cnt", match_cnt, 1);

    run_scan(16'hDA00, 4'b1101, 1'b1, lat, bcyc);
    chk("da00_ovl_cnt", match_cnt, 2);
    chk("da00_ovl_pos", first_pos, 3);
    @(posedge clk); #1;
    run_scan(16'hDA00, 4'b1101, 1'b0, lat, bcyc);
    chk("da00_noovl_cnt", match_cnt, 1);
    chk("da00_noovl_pos", first_pos, 3);
    @(posedge clk); #1;

    run_scan(16'h0000, 4'b1101, 1'b0, lat, bcyc);
    chk("zero_latency", lat, 16);
    chk("zero_found", found, 0);
    chk("zero_cnt", match_cnt, 0);
    chk("zero_pos", first_pos, 0);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("zero_no_extra_done", pulses, 0);

    // 13 raw matches: 5-bit counter holds 13, 3-bit counter saturates at 7.
    run_scan(16'h0000, 4'b0000, 1'b1, lat, bcyc);
    chk("sat_a_cnt", match_cnt, 13);
    chk("sat_b_done", b_done, 1);
    chk("sat_b_cnt", b_match_cnt, 7);
    chk("sat_b_found", b_found, 1);
    chk("sat_b_pos", b_first_pos, 3);
    @(posedge clk); #1;

    // A second start during SHIFT must not disturb the captured operands.
    data_in = 16'hD000; pattern = 4'b1101; overlap = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    data_in = 16'hFFFF; pattern = 4'b1111; overlap = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ign_latency", lat, 11);
    chk("ign_cnt", match_cnt, 1);
    chk("ign_pos", first_pos, 3);
    // Start in the cycle after the done cycle is accepted.
    @(posedge clk); #1;
    run_scan(16'hFFFF, 4'b1111, 1'b1, lat, bcyc);
    chk("b2b_latency", lat, 16);
    chk("b2b_cnt", match_cnt, 13);
    chk("b2b_pos", first_pos, 3);
    @(posedge clk); #1;

    // Reset during SHIFT cycle 5 aborts the scan with no done pulse.
    data_in = 16'hD000; pattern = 4'b1101; overlap = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", match_cnt, 0);
    chk("abort_found", found, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_scan(16'hD000, 4'b1101, 1'b0, lat, bcyc);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_cnt", match_cnt, 1);
    chk("post_rst_pos", first_pos, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
